// File: rtl/memory_bus_decoder.sv
// memory_bus_decoder
//
// Single-master memory-mapped bus decoder between a CPU data port and the
// physical memory / peripheral side. Each accepted request is decoded into a
// synchronous BRAM region, a peripheral IO region, or an unmapped error. The
// access then runs a request/ready handshake: configurable BRAM read latency,
// stalling peripherals with a timeout, and a one-cycle completion pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   cpu_req    access request, held until cpu_ready
//   cpu_wen    1 = write, 0 = read
//   cpu_addr   CPU word address
//   cpu_wdata  write data
//   cpu_ready  one-cycle completion pulse
//   cpu_rdata  read data (valid while cpu_ready; held until the next completion)
//   cpu_err    error flag (valid while cpu_ready; held until the next completion)
//   ram_addr   BRAM word address (region offset)
//   ram_wdata  BRAM write data
//   ram_wen    BRAM write strobe
//   ram_rdata  BRAM read data
//   io_addr    peripheral register index (region offset)
//   io_wdata   peripheral write data
//   io_wen     peripheral write strobe
//   io_ren     peripheral read strobe
//   io_rdata   peripheral read data
//   io_ready   peripheral completion, sampled while a strobe is high

module memory_bus_decoder #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RAM_BASE    = 32'h0000_0000,
    parameter int                RAM_AW      = 11,
    parameter int                RAM_LATENCY = 1,
    parameter logic [ADDR_W-1:0] IO_BASE     = 32'hFFFF_FFF0,
    parameter int                IO_AW       = 4,
    parameter int                IO_TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [IO_AW-1:0]  io_addr,
    output logic [DATA_W-1:0] io_wdata,
    output logic              io_wen,
    output logic              io_ren,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_ready
);

    typedef enum logic [1:0] {
        IDLE,
        RAM_ACC,
        IO_ACC,
        DONE
    } state_t;

    // One counter serves both the BRAM latency and the IO wait; it only has
    // to reach the larger terminal value minus one.
    localparam int CNT_MAX = (IO_TIMEOUT > RAM_LATENCY) ? IO_TIMEOUT : RAM_LATENCY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'(RAM_LATENCY - 1);
    localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);

    // Region sizes in ADDR_W+1 bits so a region ending exactly at the top of
    // the address space is representable.
    localparam logic [ADDR_W:0] RAM_SIZE = {{ADDR_W{1'b0}}, 1'b1} << RAM_AW;
    localparam logic [ADDR_W:0] IO_SIZE  = {{ADDR_W{1'b0}}, 1'b1} << IO_AW;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic              wen_q;
    logic [RAM_AW-1:0] ram_off_q;
    logic [IO_AW-1:0]  io_off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              load_result;
    logic [DATA_W-1:0] result_data;
    logic              result_err;

    logic [ADDR_W:0]   ram_delta;
    logic [ADDR_W:0]   io_delta;
    logic              ram_hit;
    logic              io_hit;

    // Address decode on the live CPU address. The subtraction is done one bit
    // wider than the address, so an address below the base wraps to a value of
    // at least 2**ADDR_W and fails the single "offset < size" test. This gives
    // both bounds without overflow, even for a region touching the top of the
    // address space. The low bits of the difference are the region offset.
    always_comb begin
        ram_delta = {1'b0, cpu_addr} - {1'b0, RAM_BASE};
        io_delta  = {1'b0, cpu_addr} - {1'b0, IO_BASE};
        ram_hit   = (ram_delta < RAM_SIZE);
        io_hit    = (io_delta < IO_SIZE);
    end

    // Next-state and output logic. Bus strobes and addresses are driven only
    // inside the access states; everywhere else they are held at zero.
    // load_result marks the edge that produces the completion data and error
    // that DONE will present.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        load_result = 1'b0;
        result_data = '0;
        result_err  = 1'b0;
        cpu_ready   = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_wen     = 1'b0;
        io_addr     = '0;
        io_wdata    = '0;
        io_wen      = 1'b0;
        io_ren      = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (cpu_req) begin
                    // RAM is checked first so it wins if the regions overlap.
                    if (ram_hit) begin
                        state_next = RAM_ACC;
                    end else if (io_hit) begin
                        state_next = IO_ACC;
                    end else begin
                        state_next  = DONE;
                        load_result = 1'b1;
                        result_err  = 1'b1;
                    end
                end
            end

            RAM_ACC: begin
                ram_addr  = ram_off_q;
                ram_wdata = wdata_q;
                // A write finishes after a single cycle, so the strobe is
                // high for exactly one cycle.
                ram_wen   = wen_q;
                if (wen_q) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                end else if (cnt == RAM_LAST) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                    result_data = ram_rdata;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            IO_ACC: begin
                io_addr  = io_off_q;
                io_wdata = wdata_q;
                io_wen   = wen_q;
                io_ren   = ~wen_q;
                // A peripheral answering on the final wait cycle still counts
                // as served; the timeout only fires without io_ready.
                if (io_ready) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                    result_data = wen_q ? '0 : io_rdata;
                end else if (cnt == IO_LAST) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                    result_err  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            DONE: begin
                cpu_ready  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus request capture and completion registers. The
    // request is captured as region offsets, because only the offset is ever
    // driven out. The completion registers change only when a result is
    // loaded, so cpu_rdata and cpu_err hold between completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wen_q     <= 1'b0;
            ram_off_q <= '0;
            io_off_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && cpu_req) begin
                wen_q     <= cpu_wen;
                ram_off_q <= ram_delta[RAM_AW-1:0];
                io_off_q  <= io_delta[IO_AW-1:0];
                wdata_q   <= cpu_wdata;
            end
            if (load_result) begin
                rdata_q <= result_data;
                err_q   <= result_err;
            end
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;

endmodule

// File: tb/tb_memory_bus_decoder.sv
// tb_memory_bus_decoder
//
// Self-checking bench for memory_bus_decoder. Each request is issued
// together with the completion it should produce. That expected completion is
// worked out from the address map and the access rules, and pushed into a
// scoreboard queue. A monitor pops that queue on every cpu_ready pulse.
// The driver checks per-access timing, strobe counts and the addresses
// presented on the bus. A BRAM array and a peripheral with a programmable
// response delay stand in for the physical side.

module tb_memory_bus_decoder;

    localparam int     DATA_W      = 32;
    localparam int     ADDR_W      = 32;
    localparam int     RAM_AW      = 11;
    localparam int     RAM_LATENCY = 3;
    localparam int     IO_AW       = 4;
    localparam int     IO_TIMEOUT  = 16;
    localparam longint RAM_BASE_L  = 64'h0000_0000;
    localparam longint IO_BASE_L   = 64'hFFFF_FFF0;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_rdata;
    logic [IO_AW-1:0]  io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_wen;
    logic              io_ren;
    logic [DATA_W-1:0] io_rdata;
    logic              io_ready;

    memory_bus_decoder #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .RAM_BASE    (32'h0000_0000),
        .RAM_AW      (RAM_AW),
        .RAM_LATENCY (RAM_LATENCY),
        .IO_BASE     (32'hFFFF_FFF0),
        .IO_AW       (IO_AW),
        .IO_TIMEOUT  (IO_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wen   (ram_wen),
        .ram_rdata (ram_rdata),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_wen    (io_wen),
        .io_ren    (io_ren),
        .io_rdata  (io_rdata),
        .io_ready  (io_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // BRAM stand-in: written by the DUT strobe, read combinationally so the
    // data is settled by the edge that captures it. Cleared on reset.
    logic [DATA_W-1:0] mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << RAM_AW); i++) mem[i] <= '0;
        end else if (ram_wen) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr];

    // Peripheral stand-in: answers in the io_delay-th strobe cycle, or never
    // when io_delay is 0.
    int          io_delay = 0;
    logic [31:0] io_resp  = '0;
    int          io_cnt;
    always @(posedge clk) begin
        if (rst || !(io_ren || io_wen)) io_cnt <= 0;
        else                            io_cnt <= io_cnt + 1;
    end
    assign io_ready = (io_ren || io_wen) && (io_delay != 0) && (io_cnt == io_delay - 1);
    assign io_rdata = io_resp;

    // Scoreboard and reference memory contents (word offset -> data).
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [longint];

    int n_pass  = 0;
    int n_total = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic failNow(input string name);
        n_total++;
        $display("[TB] FAIL %s: bound expired, expected completion", name);
    endtask

    // Address map: 1 = RAM, 2 = IO, 0 = unmapped; RAM is tested first.
    function automatic int regionOf(input longint a);
        if (a >= RAM_BASE_L && a < RAM_BASE_L + (64'd1 << RAM_AW)) return 1;
        if (a >= IO_BASE_L && a < IO_BASE_L + (64'd1 << IO_AW)) return 2;
        return 0;
    endfunction

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && cpu_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("[TB] FAIL unexpected_ready: got pulse 0x%0h, expected no pulse", cpu_rdata);
            end else begin
                e = exp_q.pop_front();
                checkOutput("cpu_rdata", cpu_rdata, e.rdata);
                checkOutput("cpu_err", cpu_err, e.err);
            end
        end
    end

    // Push the expected completion for one access, following the access
    // rules, and return the expected edge count and strobe counts.
    task automatic predict(input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay,
                           input logic [31:0] resp, output longint off,
                           output int lat, output int rwen, output int iren,
                           output int iwen);
        exp_t   e;
        int     kind;
        int     n;
        logic   served;
        longint a;
        a = longint'(addr);
        kind = regionOf(a);
        e.rdata = '0;
        e.err = 1'b0;
        off = 0; lat = 0; rwen = 0; iren = 0; iwen = 0;
        if (kind == 1) begin
            off = a - RAM_BASE_L;
            if (wen) begin
                ref_mem[off] = wdata;
                lat = 1;
                rwen = 1;
            end else begin
                lat = RAM_LATENCY;
                e.rdata = ref_mem.exists(off) ? ref_mem[off] : 32'h0;
            end
        end else if (kind == 2) begin
            off = a - IO_BASE_L;
            served = (delay >= 1 && delay <= IO_TIMEOUT);
            n = served ? delay : IO_TIMEOUT;
            lat = n;
            if (wen) iwen = n;
            else iren = n;
            e.rdata = (served && !wen) ? resp : 32'h0;
            e.err = ~served;
        end else begin
            e.err = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // One complete access from an idle bus: present, accept, wait for ready.
    task automatic applyStimulus(input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int delay,
                                 input logic [31:0] resp);
        longint off;
        int     exp_lat, exp_rwen, exp_iren, exp_iwen;
        int     lat, rwen_c, iren_c, iwen_c;
        bit     seen_io;
        predict(wen, addr, wdata, delay, resp, off, exp_lat, exp_rwen, exp_iren, exp_iwen);
        io_delay = delay;
        io_resp  = resp;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
        lat = 0; rwen_c = 0; iren_c = 0; iwen_c = 0; seen_io = 1'b0;
        while (!cpu_ready && lat < 100) begin
            if (ram_wen) begin
                rwen_c++;
                checkOutput("ram_addr", 64'(ram_addr), off);
                checkOutput("ram_wdata", ram_wdata, wdata);
            end
            if (io_ren) iren_c++;
            if (io_wen) iwen_c++;
            if ((io_ren || io_wen) && !seen_io) begin
                seen_io = 1'b1;
                checkOutput("io_addr", 64'(io_addr), off);
                if (wen) checkOutput("io_wdata", io_wdata, wdata);
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!cpu_ready) failNow("ready_timeout");
        else checkOutput("latency", lat, exp_lat);
        checkOutput("ram_wen_cycles", rwen_c, exp_rwen);
        checkOutput("io_ren_cycles", iren_c, exp_iren);
        checkOutput("io_wen_cycles", iwen_c, exp_iwen);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint off;
        int     d0, d1, d2, d3, wait_c, pulses, kind;
        int     stamp [3];
        logic [31:0] a;

        rst = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cpu_ready", cpu_ready, 0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 0);
        checkOutput("rst_cpu_err", cpu_err, 0);
        checkOutput("rst_ram_wen", ram_wen, 0);
        checkOutput("rst_ram_addr", 64'(ram_addr), 0);
        checkOutput("rst_io_strobes", {io_wen, io_ren}, 0);
        checkOutput("rst_io_addr", 64'(io_addr), 0);
        rst = 1'b0;

        $display("[TB] directed RAM and unmapped accesses");
        applyStimulus(1'b1, 32'h0000_0005, 32'hCAFE_F00D, 0, 0);
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 0, 0);
        applyStimulus(1'b1, 32'h0000_07FF, 32'h1357_9BDF, 0, 0);
        applyStimulus(1'b0, 32'h0000_07FF, 32'h0, 0, 0);
        applyStimulus(1'b0, 32'h0000_0800, 32'h0, 0, 0);
        applyStimulus(1'b1, 32'hFFFF_FFEF, 32'h5555_AAAA, 0, 0);

        $display("[TB] directed IO accesses");
        applyStimulus(1'b0, 32'hFFFF_FFF3, 32'h0, 5, 32'h0000_1234);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 1, 32'hA5A5_0001);
        applyStimulus(1'b0, 32'hFFFF_FFF0, 32'h0, IO_TIMEOUT, 32'h0BAD_CAFE);
        applyStimulus(1'b1, 32'hFFFF_FFF8, 32'h7777_0000, 0, 0);

        $display("[TB] reset during IO wait");
        io_delay = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'hFFFF_FFF1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        checkOutput("rst_mid_ren_before", io_ren, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_ren_after", io_ren, 0);
        checkOutput("rst_mid_ready", cpu_ready, 0);
        checkOutput("rst_mid_err_cleared", cpu_err, 0);
        rst = 1'b0;
        ref_mem.delete();
        applyStimulus(1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 0, 0);
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 0, 0);

        $display("[TB] back-to-back RAM reads with cpu_req held");
        applyStimulus(1'b1, 32'h0000_000A, $urandom, 0, 0);
        applyStimulus(1'b1, 32'h0000_000B, $urandom, 0, 0);
        applyStimulus(1'b1, 32'h0000_000C, $urandom, 0, 0);
        for (int k = 0; k < 3; k++) predict(1'b0, 32'h0000_000A + k, 32'h0, 0, 0, off, d0, d1, d2, d3);
        pulses = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_000A;
        for (int k = 0; k < 3; k++) begin
            wait_c = 0;
            while (!cpu_ready && wait_c < 50) begin
                @(posedge clk); #1;
                wait_c++;
            end
            if (!cpu_ready) begin
                failNow("b2b_ready_timeout");
            end else begin
                stamp[pulses] = cycle;
                pulses++;
            end
            if (k < 2) cpu_addr = 32'h0000_000B + k;
            else cpu_req = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("b2b_pulses", pulses, 3);
        if (pulses == 3) begin
            checkOutput("b2b_gap_1", stamp[1] - stamp[0], RAM_LATENCY + 2);
            checkOutput("b2b_gap_2", stamp[2] - stamp[1], RAM_LATENCY + 2);
        end

        $display("[TB] randomized accesses");
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                a = (kind == 3) ? 32'h0000_07FF : 32'($urandom_range(0, 15));
                applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 0, 0);
            end else if (kind <= 6) begin
                a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                applyStimulus(1'($urandom_range(0, 1)), a, $urandom,
                              $urandom_range(0, 20), $urandom);
            end else begin
                a = $urandom_range(32'h0000_0800, 32'hFFFF_FFEF);
                applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 0, 0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
